// File: rtl/ppu_pkg.sv
// Shared PPU definitions: background fetch FSM states
// and the VRAM address-map constants.
package ppu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NT,
    S_AT,
    S_PL,
    S_PH,
    S_COMMIT
  } bg_state_e;

  localparam logic [13:0] NT_BASE              = 14'h2000;
  localparam logic [9:0]  AT_OFFSET            = 10'h3C0;
  localparam logic [3:0]  PATTERN_PLANE_OFFSET = 4'h8;

endpackage

// File: rtl/bg_addr_gen.sv
// Combinational VRAM address and palette-shift generator
// for the background fetch sequencer.
module bg_addr_gen
  import ppu_pkg::*;
(
  input  bg_state_e   state_i,
  input  logic [1:0]  nt_i,
  input  logic [4:0]  cx_i,
  input  logic [4:0]  cy_i,
  input  logic [2:0]  fy_i,
  input  logic [7:0]  tile_i,
  input  logic        psel_i,
  output logic [13:0] addr_o,
  output logic [2:0]  pal_shift_o
);

  logic [13:0] nt_addr;
  logic [13:0] at_addr;
  logic [13:0] pl_addr;
  logic [13:0] ph_addr;

  assign nt_addr = NT_BASE
                 | {2'b0, nt_i, 10'b0}
                 | {4'b0, cy_i, 5'b0}
                 | {9'b0, cx_i};

  assign at_addr = NT_BASE
                 | {2'b0, nt_i, 10'b0}
                 | {4'b0, AT_OFFSET}
                 | {8'b0, cy_i[4:2], 3'b0}
                 | {11'b0, cx_i[4:2]};

  assign pl_addr = {1'b0, psel_i, tile_i, 1'b0, fy_i};
  assign ph_addr = pl_addr | {10'b0, PATTERN_PLANE_OFFSET};

  // 2-bit quadrant field inside the attribute byte
  assign pal_shift_o = {cy_i[1], cx_i[1], 1'b0};

  always_comb begin
    addr_o = '0;
    case (state_i)
      S_NT:    addr_o = nt_addr;
      S_AT:    addr_o = at_addr;
      S_PL:    addr_o = pl_addr;
      S_PH:    addr_o = ph_addr;
      default: addr_o = '0;
    endcase
  end

endmodule

// File: rtl/bg_fetch_sequencer.sv
// Per-scanline background fetch controller: NT/AT/PL/PH
// reads per 8-pixel group, presented on a valid/ready reg.
module bg_fetch_sequencer
  import ppu_pkg::*;
#(
  parameter int GROUPS_PER_LINE = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_start,
  input  logic        bg_enable,
  input  logic        bg_pattern_sel,
  input  logic [1:0]  nt_sel,
  input  logic [4:0]  coarse_x,
  input  logic [4:0]  coarse_y,
  input  logic [2:0]  fine_y,
  output logic        mem_req,
  output logic [13:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  background_pattern_low,
  output logic [7:0]  background_pattern_high,
  output logic [1:0]  bg_palette,
  output logic        grp_valid,
  input  logic        grp_ready,
  output logic        busy,
  output logic        line_done
);

  localparam logic [6:0] LAST_GRP = 7'(GROUPS_PER_LINE - 1);

  bg_state_e   state_q;
  logic [1:0]  nt_q;
  logic [4:0]  cx_q;
  logic [4:0]  cy_q;
  logic [2:0]  fy_q;
  logic        psel_q;
  logic [6:0]  grp_cnt_q;
  logic [7:0]  tile_q;
  logic [1:0]  pal_stg_q;
  logic [7:0]  pl_q;
  logic [7:0]  ph_q;
  logic [7:0]  lo_q;
  logic [7:0]  hi_q;
  logic [1:0]  pal_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;

  logic [13:0] gen_addr;
  logic [2:0]  pal_shift;
  logic        load;

  bg_addr_gen u_addr_gen (
    .state_i     (state_q),
    .nt_i        (nt_q),
    .cx_i        (cx_q),
    .cy_i        (cy_q),
    .fy_i        (fy_q),
    .tile_i      (tile_q),
    .psel_i      (psel_q),
    .addr_o      (gen_addr),
    .pal_shift_o (pal_shift)
  );

  assign mem_req = (state_q == S_NT) || (state_q == S_AT) ||
                   (state_q == S_PL) || (state_q == S_PH);
  assign mem_addr = mem_req ? gen_addr : '0;
  assign load     = !valid_q || grp_ready;

  assign background_pattern_low  = lo_q;
  assign background_pattern_high = hi_q;
  assign bg_palette = pal_q;
  assign grp_valid  = valid_q;
  assign busy       = busy_q;
  assign line_done  = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      nt_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      fy_q      <= '0;
      psel_q    <= 1'b0;
      grp_cnt_q <= '0;
      tile_q    <= '0;
      pal_stg_q <= '0;
      pl_q      <= '0;
      ph_q      <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      pal_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (valid_q && grp_ready) valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (line_start && bg_enable) begin
            nt_q      <= nt_sel;
            cx_q      <= coarse_x;
            cy_q      <= coarse_y;
            fy_q      <= fine_y;
            psel_q    <= bg_pattern_sel;
            grp_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_NT;
          end
        end
        S_NT: begin
          if (mem_ack) begin
            tile_q  <= mem_rdata;
            state_q <= S_AT;
          end
        end
        S_AT: begin
          if (mem_ack) begin
            pal_stg_q <= mem_rdata[pal_shift +: 2];
            state_q   <= S_PL;
          end
        end
        S_PL: begin
          if (mem_ack) begin
            pl_q    <= mem_rdata;
            state_q <= S_PH;
          end
        end
        S_PH: begin
          if (mem_ack) begin
            ph_q    <= mem_rdata;
            state_q <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          if (load) begin
            lo_q      <= pl_q;
            hi_q      <= ph_q;
            pal_q     <= pal_stg_q;
            valid_q   <= 1'b1;
            grp_cnt_q <= grp_cnt_q + 7'd1;
            cx_q      <= cx_q + 5'd1;
            // horizontal nametable flip on column wrap
            if (&cx_q) nt_q[0] <= ~nt_q[0];
            if (grp_cnt_q == LAST_GRP) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_NT;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bg_fetch_sequencer.sv
// Scoreboard bench for bg_fetch_sequencer: VRAM responder
// with wait states, address/group queues, handshake checks.
module tb_bg_fetch_sequencer;

  localparam int G = 2;

  logic        clk;
  logic        rst_n;
  logic        line_start;
  logic        bg_enable;
  logic        bg_pattern_sel;
  logic [1:0]  nt_sel;
  logic [4:0]  coarse_x;
  logic [4:0]  coarse_y;
  logic [2:0]  fine_y;
  logic        mem_req;
  logic [13:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [7:0]  pat_lo;
  logic [7:0]  pat_hi;
  logic [1:0]  bg_palette;
  logic        grp_valid;
  logic        grp_ready;
  logic        busy;
  logic        line_done;

  bg_fetch_sequencer #(.GROUPS_PER_LINE(G)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .line_start              (line_start),
    .bg_enable               (bg_enable),
    .bg_pattern_sel          (bg_pattern_sel),
    .nt_sel                  (nt_sel),
    .coarse_x                (coarse_x),
    .coarse_y                (coarse_y),
    .fine_y                  (fine_y),
    .mem_req                 (mem_req),
    .mem_addr                (mem_addr),
    .mem_ack                 (mem_ack),
    .mem_rdata               (mem_rdata),
    .background_pattern_low  (pat_lo),
    .background_pattern_high (pat_hi),
    .bg_palette              (bg_palette),
    .grp_valid               (grp_valid),
    .grp_ready               (grp_ready),
    .busy                    (busy),
    .line_done               (line_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [1:0] pal;
  } grp_t;

  int checks = 0;
  int errors = 0;

  logic [13:0] exp_addr[$];
  grp_t        exp_grp[$];
  logic [7:0]  rdq[$];

  int          wait_cyc = 0;
  int          wcnt = 0;
  logic        pend = 1'b0;
  logic [13:0] paddr = '0;
  int          ld_cnt = 0;
  int          busy_cnt = 0;
  int          req_cnt = 0;
  logic        hold = 1'b0;
  grp_t        prev;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // VRAM responder: ack after wait_cyc extra cycles
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      wcnt = 0;
      pend = 1'b0;
    end else begin
      mem_ack = 1'b0;
      if (mem_req) begin
        req_cnt++;
        if (pend) chk("addr_stable", mem_addr, paddr);
        if (wcnt >= wait_cyc) begin
          mem_ack = 1'b1;
          wcnt = 0;
          pend = 1'b0;
          chk("addr_q", int'(exp_addr.size() > 0), 1);
          if (exp_addr.size() > 0)
            chk("addr", mem_addr, exp_addr.pop_front());
          mem_rdata = (rdq.size() > 0) ? rdq.pop_front() : 8'h00;
        end else begin
          wcnt++;
          pend = 1'b1;
          paddr = mem_addr;
        end
      end else begin
        wcnt = 0;
        pend = 1'b0;
      end
    end
  end

  // output monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (line_done) ld_cnt++;
      if (hold) begin
        chk("hold_valid", grp_valid, 1);
        chk("hold_lo", pat_lo, prev.lo);
        chk("hold_hi", pat_hi, prev.hi);
        chk("hold_pal", bg_palette, prev.pal);
      end
      if (grp_valid && grp_ready) begin
        hold = 1'b0;
        chk("grp_q", int'(exp_grp.size() > 0), 1);
        if (exp_grp.size() > 0) begin
          prev = exp_grp.pop_front();
          chk("grp_lo", pat_lo, prev.lo);
          chk("grp_hi", pat_hi, prev.hi);
          chk("grp_pal", bg_palette, prev.pal);
        end
      end else if (grp_valid) begin
        hold = 1'b1;
        prev.lo = pat_lo;
        prev.hi = pat_hi;
        prev.pal = bg_palette;
      end else begin
        hold = 1'b0;
      end
    end
  end

  task automatic start_line(input logic en,
                            input int nt, input int cx,
                            input int cy, input int fy,
                            input int ps,
                            input logic [7:0] d[8]);
    int n, x, a, pl, sh;
    grp_t e;
    n = nt;
    x = cx;
    if (en) begin
      for (int g = 0; g < G; g++) begin
        for (int k = 0; k < 4; k++) rdq.push_back(d[4*g+k]);
        a = 'h2000 + n * 1024 + cy * 32 + x;
        exp_addr.push_back(14'(a));
        a = 'h23C0 + n * 1024 + (cy / 4) * 8 + x / 4;
        exp_addr.push_back(14'(a));
        pl = ps * 4096 + int'(d[4*g]) * 16 + fy;
        exp_addr.push_back(14'(pl));
        exp_addr.push_back(14'(pl + 8));
        sh = 2 * (((cy / 2) % 2) * 2 + (x / 2) % 2);
        e.lo = d[4*g+2];
        e.hi = d[4*g+3];
        e.pal = 2'((int'(d[4*g+1]) >> sh) & 3);
        exp_grp.push_back(e);
        x++;
        if (x == 32) begin
          x = 0;
          n = n ^ 1;
        end
      end
    end
    @(posedge clk);
    #1;
    bg_enable = en;
    nt_sel = 2'(nt);
    coarse_x = 5'(cx);
    coarse_y = 5'(cy);
    fine_y = 3'(fy);
    bg_pattern_sel = ps[0];
    line_start = 1'b1;
    @(posedge clk);
    #1;
    line_start = 1'b0;
    bg_enable = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (ld_cnt < target && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("timeout", int'(ld_cnt >= target), 1);
    repeat (3) @(negedge clk);
    chk("addr_drain", exp_addr.size(), 0);
    chk("grp_drain", exp_grp.size(), 0);
  endtask

  logic [7:0] d[8];

  initial begin
    int t;
    rst_n = 1'b0;
    line_start = 1'b0;
    bg_enable = 1'b0;
    bg_pattern_sel = 1'b0;
    nt_sel = '0;
    coarse_x = '0;
    coarse_y = '0;
    fine_y = '0;
    grp_ready = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", grp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", line_done, 0);
    chk("rst_lo", pat_lo, 0);
    chk("rst_hi", pat_hi, 0);
    chk("rst_pal", bg_palette, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // zero-wait, 5 cycles per group
    ld_cnt = 0;
    busy_cnt = 0;
    d = '{8'h24, 8'hE4, 8'h55, 8'hAA, 8'h11, 8'h22, 8'h33, 8'h44};
    start_line(1, 0, 0, 0, 3, 1, d);
    wait_done(1);
    chk("busy_cycles", busy_cnt, 5 * G);
    chk("done_pulses", ld_cnt, 1);

    // palette quadrants
    ld_cnt = 0;
    d = '{8'h00, 8'hE4, 8'h01, 8'h02, 8'h07, 8'hE4, 8'h03, 8'h04};
    start_line(1, 0, 2, 2, 0, 0, d);
    wait_done(1);
    ld_cnt = 0;
    start_line(1, 0, 2, 0, 5, 1, d);
    wait_done(1);

    // column wrap, nt[1] preserved
    ld_cnt = 0;
    d = '{8'h10, 8'h1B, 8'h21, 8'h22, 8'h30, 8'h6C, 8'h31, 8'h32};
    start_line(1, 0, 31, 5, 1, 0, d);
    wait_done(1);
    ld_cnt = 0;
    start_line(1, 2, 31, 29, 7, 1, d);
    wait_done(1);

    // backpressure
    ld_cnt = 0;
    grp_ready = 1'b0;
    d = '{8'hA0, 8'h93, 8'hC1, 8'hC2, 8'hB0, 8'h39, 8'hD1, 8'hD2};
    start_line(1, 1, 6, 3, 2, 0, d);
    repeat (20) @(negedge clk);
    chk("bp_req", mem_req, 0);
    chk("bp_valid", grp_valid, 1);
    chk("bp_busy", busy, 1);
    chk("bp_lo", pat_lo, 8'hC1);
    chk("bp_done", ld_cnt, 0);
    @(posedge clk);
    #1 grp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_line_done", line_done, 1);
    chk("bp_busy_drop", busy, 0);
    chk("bp_lo2", pat_lo, 8'hD1);
    wait_done(1);

    // memory wait states
    ld_cnt = 0;
    busy_cnt = 0;
    wait_cyc = 3;
    d = '{8'h5A, 8'hFF, 8'h0F, 8'hF0, 8'hA5, 8'h00, 8'h3C, 8'hC3};
    start_line(1, 3, 12, 17, 6, 1, d);
    wait_done(1);
    chk("wait_busy", busy_cnt, G * (4 * (wait_cyc + 1) + 1));
    wait_cyc = 0;

    // disabled line
    ld_cnt = 0;
    req_cnt = 0;
    start_line(0, 0, 0, 0, 0, 0, d);
    repeat (20) @(negedge clk);
    chk("dis_req", req_cnt, 0);
    chk("dis_busy", busy, 0);
    chk("dis_done", ld_cnt, 0);

    // reset during PL fetch
    ld_cnt = 0;
    wait_cyc = 2;
    d = '{8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    start_line(1, 0, 4, 4, 4, 0, d);
    t = 0;
    while (exp_addr.size() > 4 * G - 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("pl_reach", int'(exp_addr.size() == 4 * G - 2), 1);
    @(posedge clk);
    #1;
    chk("pl_req", mem_addr, 14'h0774);
    rst_n = 1'b0;
    #1;
    chk("mr_req", mem_req, 0);
    chk("mr_addr", mem_addr, 0);
    chk("mr_busy", busy, 0);
    chk("mr_valid", grp_valid, 0);
    chk("mr_done", line_done, 0);
    exp_addr.delete();
    exp_grp.delete();
    rdq.delete();
    wait_cyc = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    ld_cnt = 0;
    d = '{8'h24, 8'hE4, 8'h55, 8'hAA, 8'h11, 8'h22, 8'h33, 8'h44};
    start_line(1, 0, 0, 0, 3, 1, d);
    wait_done(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
